// File: rtl/tx_ant_switch_pkg.sv
// Shared definitions for the TX/RX antenna-diversity blocks: antenna
// identifiers, antenna-mode encodings, switch-sequencer state encodings
// and the antenna pick rule used when a packet starts.
package tx_ant_switch_pkg;

    localparam logic ANT1 = 1'b0;
    localparam logic ANT2 = 1'b1;

    typedef enum logic [1:0] {
        MODE_FOLLOW = 2'd0,
        MODE_ANT1   = 2'd1,
        MODE_ANT2   = 2'd2,
        MODE_ALT    = 2'd3
    } ant_mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACTIVE = 2'd2,
        TAIL   = 2'd3
    } sw_state_e;

    // follow_ant already folds in a same-cycle RX commit; alt_ant is the
    // current alternation phase.
    function automatic logic pick_antenna(input ant_mode_e mode,
                                          input logic      follow_ant,
                                          input logic      alt_ant);
        logic ant;
        case (mode)
            MODE_FOLLOW: ant = follow_ant;
            MODE_ANT1:   ant = ANT1;
            MODE_ANT2:   ant = ANT2;
            default:     ant = alt_ant;
        endcase
        return ant;
    endfunction

endpackage

// File: rtl/tx_ant_switch.sv
// TX antenna switch: picks the transmit antenna per packet, sequences
// T/R settle, PA enable and receiver blanking around the packet, and
// demultiplexes TX IQ samples onto the selected antenna's DAC path.
module tx_ant_switch
    import tx_ant_switch_pkg::*;
#(
    parameter int IQ_DATA_WIDTH = 16,
    parameter int SETTLE_WIDTH  = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [1:0]                 ant_mode,
    input  logic                       rx_ant_select,
    input  logic                       rx_ant_valid,
    input  logic [SETTLE_WIDTH-1:0]    settle_cycles,
    input  logic [SETTLE_WIDTH-1:0]    tail_cycles,
    input  logic                       tx_req,
    output logic                       tx_ack,
    input  logic [2*IQ_DATA_WIDTH-1:0] tx_data_in,
    input  logic                       tx_data_in_strobe,
    output logic [2*IQ_DATA_WIDTH-1:0] tx_data_ant1_out,
    output logic                       tx_data_ant1_strobe,
    output logic [2*IQ_DATA_WIDTH-1:0] tx_data_ant2_out,
    output logic                       tx_data_ant2_strobe,
    output logic                       pa_en_1,
    output logic                       pa_en_2,
    output logic                       rx_blank,
    output logic                       tx_ant_select
);

    localparam int SAMPLE_W = 2 * IQ_DATA_WIDTH;
    localparam logic [SETTLE_WIDTH-1:0] COUNT_ONE = {{(SETTLE_WIDTH-1){1'b0}}, 1'b1};

    // Counter stops at all-ones so a live threshold change can never wrap it.
    function automatic logic [SETTLE_WIDTH-1:0] count_up(input logic [SETTLE_WIDTH-1:0] c);
        return (&c) ? c : c + COUNT_ONE;
    endfunction

    sw_state_e               state, next_state;
    logic [SETTLE_WIDTH-1:0] count, next_count;
    logic                    last_rx_ant;
    logic                    alt_toggle, next_alt_toggle;
    logic                    next_ant_select;
    logic                    next_ack, next_pa_1, next_pa_2, next_blank;
    logic                    follow_ant;
    logic                    routing;
    logic                    route_1, route_2;

    // A commit arriving in the same cycle as the packet start wins over the stored one.
    assign follow_ant = rx_ant_valid ? rx_ant_select : last_rx_ant;

    // Samples flow while the PA is up, including the tail so the pipeline drains.
    assign routing = enable && tx_data_in_strobe && (state == ACTIVE || state == TAIL);
    assign route_1 = routing && (tx_ant_select == ANT1);
    assign route_2 = routing && (tx_ant_select == ANT2);

    // Track the most recent antenna committed by the RX selector, whatever TX is doing.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_rx_ant <= ANT1;
        end else if (rx_ant_valid) begin
            last_rx_ant <= rx_ant_select;
        end
    end

    // Next-state and next-output logic for the switch sequencer.
    always_comb begin
        next_state      = state;
        next_count      = count;
        next_alt_toggle = alt_toggle;
        next_ant_select = tx_ant_select;
        next_ack        = tx_ack;
        next_pa_1       = pa_en_1;
        next_pa_2       = pa_en_2;
        next_blank      = rx_blank;

        if (!enable) begin
            next_state = IDLE;
            next_count = '0;
            next_ack   = 1'b0;
            next_pa_1  = 1'b0;
            next_pa_2  = 1'b0;
            next_blank = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    next_count = '0;
                    next_ack   = 1'b0;
                    next_pa_1  = 1'b0;
                    next_pa_2  = 1'b0;
                    next_blank = 1'b0;
                    if (tx_req) begin
                        next_state      = SETTLE;
                        next_blank      = 1'b1;
                        next_ant_select = pick_antenna(ant_mode_e'(ant_mode), follow_ant, alt_toggle);
                        if (ant_mode_e'(ant_mode) == MODE_ALT) begin
                            next_alt_toggle = ~alt_toggle;
                        end
                    end
                end
                SETTLE: begin
                    if (!tx_req) begin
                        next_state = IDLE;
                        next_count = '0;
                        next_blank = 1'b0;
                    end else if (count == settle_cycles) begin
                        next_state = ACTIVE;
                        next_count = '0;
                        next_ack   = 1'b1;
                        next_pa_1  = (tx_ant_select == ANT1);
                        next_pa_2  = (tx_ant_select == ANT2);
                    end else begin
                        next_count = count_up(count);
                    end
                end
                ACTIVE: begin
                    if (!tx_req) begin
                        next_state = TAIL;
                        next_count = '0;
                        next_ack   = 1'b0;
                    end
                end
                TAIL: begin
                    if (count == tail_cycles) begin
                        next_state = IDLE;
                        next_count = '0;
                        next_pa_1  = 1'b0;
                        next_pa_2  = 1'b0;
                        next_blank = 1'b0;
                    end else begin
                        next_count = count_up(count);
                    end
                end
                default: begin
                    next_state = IDLE;
                    next_count = '0;
                    next_ack   = 1'b0;
                    next_pa_1  = 1'b0;
                    next_pa_2  = 1'b0;
                    next_blank = 1'b0;
                end
            endcase
        end
    end

    // Sequencer state and registered control outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            count         <= '0;
            alt_toggle    <= ANT1;
            tx_ant_select <= ANT1;
            tx_ack        <= 1'b0;
            pa_en_1       <= 1'b0;
            pa_en_2       <= 1'b0;
            rx_blank      <= 1'b0;
        end else begin
            state         <= next_state;
            count         <= next_count;
            alt_toggle    <= next_alt_toggle;
            tx_ant_select <= next_ant_select;
            tx_ack        <= next_ack;
            pa_en_1       <= next_pa_1;
            pa_en_2       <= next_pa_2;
            rx_blank      <= next_blank;
        end
    end

    // Registered demux: the selected path carries the sample, the other stays zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_data_ant1_out    <= '0;
            tx_data_ant1_strobe <= 1'b0;
            tx_data_ant2_out    <= '0;
            tx_data_ant2_strobe <= 1'b0;
        end else begin
            tx_data_ant1_out    <= route_1 ? tx_data_in : {SAMPLE_W{1'b0}};
            tx_data_ant1_strobe <= route_1;
            tx_data_ant2_out    <= route_2 ? tx_data_in : {SAMPLE_W{1'b0}};
            tx_data_ant2_strobe <= route_2;
        end
    end

endmodule

// File: tb/tb_tx_ant_switch.sv
// Bench for tx_ant_switch: directed packet scenarios plus randomized packet
// sequences checked against a per-packet timeline model.
module tb_tx_ant_switch;

    localparam int IQW = 16;
    localparam int SW  = 8;

    logic           clock = 1'b0;
    logic           reset, enable;
    logic [1:0]     ant_mode;
    logic           rx_ant_select, rx_ant_valid;
    logic [SW-1:0]  settle_cycles, tail_cycles;
    logic           tx_req, tx_ack;
    logic [2*IQW-1:0] tx_data_in, tx_data_ant1_out, tx_data_ant2_out;
    logic           tx_data_in_strobe, tx_data_ant1_strobe, tx_data_ant2_strobe;
    logic           pa_en_1, pa_en_2, rx_blank, tx_ant_select;

    int checks = 0;
    int errors = 0;

    // Model state: last RX commit, alternation phase, selected antenna,
    // and the sample expected on the outputs in the next cycle.
    bit          m_last_rx, m_alt, m_sel;
    bit          pend_v, pend_ant;
    logic [31:0] pend_d;

    logic [4:0]  ctl;
    logic [65:0] dat;
    assign ctl = {rx_blank, tx_ack, pa_en_1, pa_en_2, tx_ant_select};
    assign dat = {tx_data_ant1_strobe, tx_data_ant1_out, tx_data_ant2_strobe, tx_data_ant2_out};

    always #5 clock = ~clock;

    tx_ant_switch #(.IQ_DATA_WIDTH(IQW), .SETTLE_WIDTH(SW)) dut (
        .clock(clock), .reset(reset), .enable(enable), .ant_mode(ant_mode),
        .rx_ant_select(rx_ant_select), .rx_ant_valid(rx_ant_valid),
        .settle_cycles(settle_cycles), .tail_cycles(tail_cycles),
        .tx_req(tx_req), .tx_ack(tx_ack),
        .tx_data_in(tx_data_in), .tx_data_in_strobe(tx_data_in_strobe),
        .tx_data_ant1_out(tx_data_ant1_out), .tx_data_ant1_strobe(tx_data_ant1_strobe),
        .tx_data_ant2_out(tx_data_ant2_out), .tx_data_ant2_strobe(tx_data_ant2_strobe),
        .pa_en_1(pa_en_1), .pa_en_2(pa_en_2), .rx_blank(rx_blank), .tx_ant_select(tx_ant_select)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        tx_req            = 1'b0;
        tx_data_in_strobe = 1'b0;
        tx_data_in        = '0;
        rx_ant_valid      = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; ant_mode = 2'd0; rx_ant_select = 1'b0;
        settle_cycles = '0; tail_cycles = '0;
        idle_inputs();
        repeat (3) step();
        checks++;
        if ({ctl, dat} !== 71'd0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0", {ctl, dat});
        end
        reset = 1'b0; enable = 1'b1;
        m_last_rx = 1'b0; m_alt = 1'b0; m_sel = 1'b0;
        step();
        checks++;
        if ({ctl, dat} !== 71'd0) begin
            errors++; $display("FAIL idle_after_reset: got %h want 0", {ctl, dat});
        end
    endtask

    task automatic test_follow_route_tail();
        ant_mode = 2'd0; settle_cycles = 8'd4; tail_cycles = 8'd3;
        rx_ant_select = 1'b1; rx_ant_valid = 1'b1; step(); rx_ant_valid = 1'b0; m_last_rx = 1'b1;
        tx_req = 1'b1; step();
        checks++;
        if (ctl !== 5'b10001) begin errors++; $display("FAIL follow_settle_start: got %b want 10001", ctl); end
        repeat (4) step();
        checks++;
        if (ctl !== 5'b10001) begin errors++; $display("FAIL follow_settle_end: got %b want 10001", ctl); end
        step();
        checks++;
        if (ctl !== 5'b11011) begin errors++; $display("FAIL follow_ack: got %b want 11011", ctl); end
        tx_data_in = 32'h12345678; tx_data_in_strobe = 1'b1; step();
        checks++;
        if (dat !== {1'b0, 32'h0, 1'b1, 32'h12345678}) begin
            errors++; $display("FAIL route_ant2: got %h want %h", dat, {1'b0, 32'h0, 1'b1, 32'h12345678});
        end
        tx_req = 1'b0; tx_data_in = 32'hCAFEF00D; step();
        checks++;
        if (ctl !== 5'b10011) begin errors++; $display("FAIL tail_ack_drop: got %b want 10011", ctl); end
        checks++;
        if (dat !== {1'b0, 32'h0, 1'b1, 32'hCAFEF00D}) begin
            errors++; $display("FAIL tail_last_active_sample: got %h", dat);
        end
        tx_data_in = 32'h0BADBEEF; step();
        checks++;
        if (dat !== {1'b0, 32'h0, 1'b1, 32'h0BADBEEF}) begin
            errors++; $display("FAIL tail_flush_sample: got %h", dat);
        end
        tx_data_in_strobe = 1'b0; step(); step();
        checks++;
        if (ctl !== 5'b10011) begin errors++; $display("FAIL tail_hold: got %b want 10011", ctl); end
        step();
        checks++;
        if (ctl !== 5'b00001) begin errors++; $display("FAIL tail_end: got %b want 00001", ctl); end
        m_sel = 1'b1;
    endtask

    task automatic test_alternate();
        bit exp_seq [3] = '{1'b0, 1'b1, 1'b0};
        reset = 1'b1; idle_inputs(); step(); reset = 1'b0;
        m_last_rx = 1'b0; m_alt = 1'b0; m_sel = 1'b0;
        ant_mode = 2'd3; settle_cycles = '0; tail_cycles = '0;
        for (int p = 0; p < 3; p++) begin
            tx_req = 1'b1; step();
            checks++;
            if (tx_ant_select !== exp_seq[p]) begin
                errors++; $display("FAIL alt_select pkt%0d: got %b want %b", p, tx_ant_select, exp_seq[p]);
            end
            step();
            checks++;
            if ({pa_en_1, pa_en_2, tx_ack} !== {~exp_seq[p], exp_seq[p], 1'b1}) begin
                errors++; $display("FAIL alt_pa pkt%0d: got %b", p, {pa_en_1, pa_en_2, tx_ack});
            end
            step(); tx_req = 1'b0;
            step(); step();
            checks++;
            if (ctl !== {4'b0000, exp_seq[p]}) begin
                errors++; $display("FAIL alt_end pkt%0d: got %b", p, ctl);
            end
        end
        m_alt = 1'b1; m_sel = 1'b0;
    endtask

    task automatic test_abort();
        ant_mode = 2'd1; settle_cycles = 8'd10; tail_cycles = '0;
        tx_req = 1'b1; step();
        tx_data_in = 32'h55AA55AA; tx_data_in_strobe = 1'b1;
        step(); step();
        checks++;
        if (ctl !== 5'b10000) begin errors++; $display("FAIL abort_settle: got %b want 10000", ctl); end
        checks++;
        if ({tx_data_ant1_strobe, tx_data_ant2_strobe} !== 2'b00) begin
            errors++; $display("FAIL settle_strobe_drop: got %b want 00", {tx_data_ant1_strobe, tx_data_ant2_strobe});
        end
        tx_req = 1'b0; tx_data_in_strobe = 1'b0; step();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ctl !== 5'b00000) begin errors++; $display("FAIL abort_idle c%0d: got %b want 00000", i, ctl); end
            step();
        end
        m_sel = 1'b0;
    endtask

    task automatic test_boundary_zero();
        ant_mode = 2'd2; settle_cycles = '0; tail_cycles = '0;
        tx_req = 1'b1; step();
        checks++;
        if (ctl !== 5'b10001) begin errors++; $display("FAIL zero_settle_start: got %b want 10001", ctl); end
        step();
        checks++;
        if (ctl !== 5'b11011) begin errors++; $display("FAIL zero_settle_ack: got %b want 11011", ctl); end
        tx_req = 1'b0; step();
        checks++;
        if (ctl !== 5'b10011) begin errors++; $display("FAIL zero_tail_hold: got %b want 10011", ctl); end
        step();
        checks++;
        if (ctl !== 5'b00001) begin errors++; $display("FAIL zero_tail_off: got %b want 00001", ctl); end
        m_sel = 1'b1;
    endtask

    task automatic test_rx_mid_packet();
        ant_mode = 2'd0; settle_cycles = 8'd1; tail_cycles = 8'd1;
        rx_ant_select = 1'b0; rx_ant_valid = 1'b1; step(); rx_ant_valid = 1'b0; m_last_rx = 1'b0;
        tx_req = 1'b1; step(); step(); step();
        checks++;
        if (ctl !== 5'b11100) begin errors++; $display("FAIL mid_active: got %b want 11100", ctl); end
        rx_ant_select = 1'b1; rx_ant_valid = 1'b1; step(); rx_ant_valid = 1'b0; m_last_rx = 1'b1;
        checks++;
        if (ctl !== 5'b11100) begin errors++; $display("FAIL mid_packet_hold: got %b want 11100", ctl); end
        tx_req = 1'b0; step(); step(); step();
        checks++;
        if (ctl !== 5'b00000) begin errors++; $display("FAIL mid_packet_end: got %b want 00000", ctl); end
        tx_req = 1'b1; step();
        checks++;
        if (tx_ant_select !== 1'b1) begin errors++; $display("FAIL next_uses_new: got %b want 1", tx_ant_select); end
        step(); step(); tx_req = 1'b0; step(); step(); step();
        rx_ant_select = 1'b0; rx_ant_valid = 1'b1; tx_req = 1'b1; step();
        rx_ant_valid = 1'b0; m_last_rx = 1'b0;
        checks++;
        if (tx_ant_select !== 1'b0) begin errors++; $display("FAIL same_cycle_valid: got %b want 0", tx_ant_select); end
        tx_req = 1'b0; step();
        m_sel = 1'b0;
    endtask

    task automatic test_enable_reset();
        ant_mode = 2'd2; settle_cycles = '0; tail_cycles = 8'd2;
        tx_req = 1'b1; step(); step();
        tx_data_in = 32'h13579BDF; tx_data_in_strobe = 1'b1; step();
        checks++;
        if (dat !== {1'b0, 32'h0, 1'b1, 32'h13579BDF}) begin errors++; $display("FAIL pre_disable_route: got %h", dat); end
        enable = 1'b0; step();
        checks++;
        if ({ctl, dat} !== {5'b00001, 66'd0}) begin errors++; $display("FAIL disable_clear: got %h", {ctl, dat}); end
        tx_req = 1'b0; tx_data_in_strobe = 1'b0; enable = 1'b1; step();
        checks++;
        if (ctl !== 5'b00001) begin errors++; $display("FAIL reenable_idle: got %b want 00001", ctl); end
        tx_req = 1'b1; step(); step();
        tx_data_in_strobe = 1'b1;
        reset = 1'b1; step();
        checks++;
        if ({ctl, dat} !== 71'd0) begin errors++; $display("FAIL reset_mid_active: got %h want 0", {ctl, dat}); end
        reset = 1'b0; tx_req = 1'b0; tx_data_in_strobe = 1'b0; step();
        m_last_rx = 1'b0; m_alt = 1'b0; m_sel = 1'b0;
    endtask

    // Each packet is described by its start cycle k=0, settle n, active
    // length and tail; expected outputs follow from that timeline.
    task automatic test_random();
        int n, tl, len, r, e, vk, mode;
        bit ant, rx_bit, do_pulse, hold_over, v, pa_on;
        logic [4:0]  exp_ctl;
        logic [65:0] exp_dat;
        logic [31:0] d;
        idle_inputs(); step();
        pend_v = 1'b0; pend_ant = 1'b0; pend_d = '0;
        ant = m_sel;
        for (int p = 0; p < 40; p++) begin
            n = $urandom_range(0, 6); tl = $urandom_range(0, 5); len = $urandom_range(1, 8);
            mode = $urandom_range(0, 3);
            hold_over = ($urandom_range(0, 3) == 0);
            r = n + 2 + len;
            e = r + tl + 2 + (hold_over ? 0 : $urandom_range(0, 3));
            do_pulse = $urandom_range(0, 1);
            vk = $urandom_range(0, e - 1);
            rx_bit = $urandom_range(0, 1);
            settle_cycles = SW'(n); tail_cycles = SW'(tl); ant_mode = 2'(mode);
            for (int k = 0; k < e; k++) begin
                pa_on = (k >= n + 2) && (k < r + tl + 2);
                exp_ctl = {(k >= 1 && k < r + tl + 2), (k >= n + 2 && k < r + 1),
                           (pa_on && ant == 1'b0), (pa_on && ant == 1'b1), m_sel};
                exp_dat = {(pend_v && !pend_ant), ((pend_v && !pend_ant) ? pend_d : 32'h0),
                           (pend_v && pend_ant), ((pend_v && pend_ant) ? pend_d : 32'h0)};
                checks++;
                if (ctl !== exp_ctl) begin
                    errors++; $display("FAIL rand_ctl pkt%0d k%0d: got %b want %b", p, k, ctl, exp_ctl);
                end
                checks++;
                if (dat !== exp_dat) begin
                    errors++; $display("FAIL rand_data pkt%0d k%0d: got %h want %h", p, k, dat, exp_dat);
                end
                rx_ant_select = rx_bit;
                rx_ant_valid  = do_pulse && (k == vk);
                if (rx_ant_valid) m_last_rx = rx_bit;
                if (k == 0) begin
                    case (mode)
                        0:       ant = m_last_rx;
                        1:       ant = 1'b0;
                        2:       ant = 1'b1;
                        default: begin ant = m_alt; m_alt = ~m_alt; end
                    endcase
                    m_sel = ant;
                end
                tx_req = (k < r) || (hold_over && k > r);
                v = ($urandom_range(0, 1) == 1);
                d = $urandom;
                tx_data_in_strobe = v; tx_data_in = d;
                pend_v = v && (k >= n + 2) && (k <= r + tl + 1);
                pend_d = d; pend_ant = ant;
                step();
            end
        end
        idle_inputs(); step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_follow_route_tail();
        test_alternate();
        test_abort();
        test_boundary_zero();
        test_rx_mid_packet();
        test_enable_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
